// File: rtl/temp_sensor_spi_sampler.sv
// Periodic SPI sampler for the board temperature sensor: shifts in 16-bit frames,
// sign-extends the 13-bit reading and drives a hysteresis over-temperature alarm.
module temp_sensor_spi_sampler #(
   parameter int CLK_DIV       = 25,
   parameter int SAMPLE_PERIOD = 5000000
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        enable,
   input  logic        start_once,
   input  logic [15:0] alarm_hi,
   input  logic [15:0] alarm_lo,
   output logic        sensor_cs_n,
   output logic        sensor_sclk,
   input  logic        sensor_miso,
   output logic [15:0] temp_data,
   output logic        temp_valid,
   output logic [15:0] sample_count,
   output logic        alarm,
   output logic        busy,
   output logic [2:0]  fsm_state
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int TW = $clog2(SAMPLE_PERIOD);
   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state;
   logic [TW-1:0]     timer;
   logic              tick;
   logic              pending;
   logic [DW-1:0]     div_cnt;
   logic              phase;
   logic [3:0]        bit_cnt;
   logic [15:0]       shreg;
   logic              trigger;
   logic              div_last;
   logic signed [15:0] new_temp;

   assign trigger     = tick | start_once;
   assign div_last    = (div_cnt == DIV_LAST);
   assign new_temp    = {{3{shreg[15]}}, shreg[15:3]};
   assign sensor_cs_n = (state == S_IDLE) || (state == S_DONE);
   assign sensor_sclk = (state == S_SHIFT) && phase;
   assign busy        = (state != S_IDLE);
   assign fsm_state   = state;

   // Registered tick lands exactly SAMPLE_PERIOD cycles after enable rises.
   always_ff @(posedge ACLK) begin
      if (ARESET || !enable) begin
         timer <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= (timer == TIMER_LAST);
         if (timer == TIMER_LAST) timer <= '0;
         else                     timer <= timer + 1'b1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state        <= S_IDLE;
         pending      <= 1'b0;
         div_cnt      <= '0;
         phase        <= 1'b0;
         bit_cnt      <= 4'd0;
         shreg        <= 16'd0;
         temp_data    <= 16'd0;
         temp_valid   <= 1'b0;
         sample_count <= 16'd0;
         alarm        <= 1'b0;
      end else begin
         temp_valid <= 1'b0;
         if (state != S_IDLE && trigger) pending <= 1'b1;
         case (state)
            S_IDLE: begin
               if (trigger || pending) begin
                  state   <= S_SETUP;
                  pending <= 1'b0;
                  div_cnt <= '0;
               end
            end
            S_SETUP: begin
               if (div_last) begin
                  div_cnt <= '0;
                  phase   <= 1'b0;
                  bit_cnt <= 4'd15;
                  state   <= S_SHIFT;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            S_SHIFT: begin
               // Sample on the first cycle of the high half, i.e. when sclk rises.
               if (phase && div_cnt == '0) shreg <= {shreg[14:0], sensor_miso};
               if (div_last) begin
                  div_cnt <= '0;
                  phase   <= ~phase;
                  if (phase) begin
                     if (bit_cnt == 4'd0) state <= S_HOLD;
                     else                 bit_cnt <= bit_cnt - 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            S_HOLD: begin
               // Results register here so they are visible during the DONE cycle.
               if (div_last) begin
                  div_cnt      <= '0;
                  state        <= S_DONE;
                  temp_valid   <= 1'b1;
                  temp_data    <= new_temp;
                  sample_count <= sample_count + 16'd1;
                  if (new_temp > $signed(alarm_hi))      alarm <= 1'b1;
                  else if (new_temp < $signed(alarm_lo)) alarm <= 1'b0;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_temp_sensor_spi_sampler.sv
// Directed bench for temp_sensor_spi_sampler with a behavioural sensor and a
// scoreboard of expected temperature/count/alarm per frame.
module tb_temp_sensor_spi_sampler;

   localparam int CLK_DIV       = 4;
   localparam int SAMPLE_PERIOD = 100;

   logic        tb_ACLK = 1'b0;
   logic        ARESET;
   logic        enable;
   logic        start_once;
   logic [15:0] alarm_hi;
   logic [15:0] alarm_lo;
   logic        sensor_cs_n;
   logic        sensor_sclk;
   logic        sensor_miso;
   logic [15:0] temp_data;
   logic        temp_valid;
   logic [15:0] sample_count;
   logic        alarm;
   logic        busy;
   logic [2:0]  fsm_state;

   always #5 tb_ACLK = ~tb_ACLK;

   temp_sensor_spi_sampler #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD)) dut (
      .ACLK(tb_ACLK), .ARESET(ARESET), .enable(enable), .start_once(start_once),
      .alarm_hi(alarm_hi), .alarm_lo(alarm_lo), .sensor_cs_n(sensor_cs_n),
      .sensor_sclk(sensor_sclk), .sensor_miso(sensor_miso), .temp_data(temp_data),
      .temp_valid(temp_valid), .sample_count(sample_count), .alarm(alarm),
      .busy(busy), .fsm_state(fsm_state)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] dir_q[$];
   logic [15:0] exp_temp_q[$];
   logic [15:0] exp_cnt_q[$];
   logic        exp_alarm_q[$];
   logic        model_alarm = 1'b0;
   logic [15:0] model_cnt = 16'd0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [15:0] f);
      logic signed [15:0] t;
      t = {{3{f[15]}}, f[15:3]};
      if (t > $signed(alarm_hi))      model_alarm = 1'b1;
      else if (t < $signed(alarm_lo)) model_alarm = 1'b0;
      model_cnt = model_cnt + 16'd1;
      exp_temp_q.push_back(t);
      exp_cnt_q.push_back(model_cnt);
      exp_alarm_q.push_back(model_alarm);
   endtask

   // Sensor model: frame chosen when cs_n falls, one bit per sclk rise, MSB first.
   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b0;
   logic        idle_bit = 1'b0;
   logic [15:0] cur_frame = 16'd0;
   logic [4:0]  rise_cnt = 5'd0;
   logic [3:0]  bit_idx;

   assign bit_idx     = 4'd15 - rise_cnt[3:0];
   assign sensor_miso = sensor_cs_n ? idle_bit : cur_frame[bit_idx];

   always @(posedge tb_ACLK) begin : sensor
      logic [15:0] f;
      prev_cs   <= sensor_cs_n;
      prev_sclk <= sensor_sclk;
      idle_bit  <= ~idle_bit;
      if (!sensor_cs_n && prev_cs) begin
         if (dir_q.size() > 0) f = dir_q.pop_front();
         else                  f = 16'($urandom_range(0, 65535));
         cur_frame <= f;
         rise_cnt  <= 5'd0;
         push_exp(f);
      end else if (sensor_sclk && !prev_sclk) begin
         rise_cnt <= rise_cnt + 5'd1;
      end
   end

   // Scoreboard side: compare on temp_valid, and flag output changes outside DONE.
   logic [15:0] prev_td;
   logic [15:0] prev_sc;
   logic        prev_al;
   logic        rst_d = 1'b1;

   always @(negedge tb_ACLK) begin
      if (temp_valid) begin
         check("unexpected_valid", 16'(exp_temp_q.size() > 0), 16'd1);
         if (exp_temp_q.size() > 0) begin
            check("temp_data", temp_data, exp_temp_q.pop_front());
            check("sample_count", sample_count, exp_cnt_q.pop_front());
            check("alarm", 16'(alarm), 16'(exp_alarm_q.pop_front()));
         end
      end
      if (!ARESET && !rst_d &&
          (temp_data !== prev_td || sample_count !== prev_sc || alarm !== prev_al))
         check("change_outside_done", 16'(temp_valid), 16'd1);
      prev_td = temp_data;
      prev_sc = sample_count;
      prev_al = alarm;
      rst_d   = ARESET;
   end

   task automatic pulse_start();
      start_once = 1'b1;
      @(negedge tb_ACLK);
      start_once = 1'b0;
   endtask

   task automatic wait_quiet(input int budget);
      int n;
      int low;
      n = 0;
      low = 0;
      while (low < 3 && n < budget) begin
         @(negedge tb_ACLK);
         n++;
         low = busy ? 0 : low + 1;
      end
      check("quiet_timeout", 16'(low >= 3), 16'd1);
   endtask

   task automatic flush_model();
      exp_temp_q.delete();
      exp_cnt_q.delete();
      exp_alarm_q.delete();
      model_alarm = 1'b0;
      model_cnt   = 16'd0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      int cs_low;
      int vcount;
      int gap;
      logic busy_seen;

      ARESET = 1'b1; enable = 1'b0; start_once = 1'b0;
      alarm_hi = 16'h7FFF; alarm_lo = 16'h8000;

      // Reset held with MISO toggling from the idle model
      repeat (5) begin
         @(negedge tb_ACLK);
         check("rst_cs_n", 16'(sensor_cs_n), 16'd1);
         check("rst_sclk", 16'(sensor_sclk), 16'd0);
      end
      ARESET = 1'b0;
      @(negedge tb_ACLK);
      check("rst_temp_data", temp_data, 16'd0);
      check("rst_valid", 16'(temp_valid), 16'd0);
      check("rst_count", sample_count, 16'd0);
      check("rst_alarm", 16'(alarm), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_state", 16'(fsm_state), 16'd0);

      // Single shot, 50.0 C
      dir_q.push_back(16'h1900);
      pulse_start();
      check("lat_cs_n", 16'(sensor_cs_n), 16'd0);
      check("lat_busy", 16'(busy), 16'd1);
      n = 1;
      cs_low = sensor_cs_n ? 0 : 1;
      while (!temp_valid && n < 400) begin
         @(negedge tb_ACLK);
         n++;
         if (!sensor_cs_n) cs_low++;
      end
      check("valid_cycle", 16'(n), 16'd137);
      check("cs_low_cycles", 16'(cs_low), 16'd136);
      check("sclk_rises", 16'(rise_cnt), 16'd16);
      check("single_temp", temp_data, 16'h0320);
      @(negedge tb_ACLK);
      check("valid_one_cycle", 16'(temp_valid), 16'd0);
      check("busy_after_done", 16'(busy), 16'd0);

      // Negative value
      dir_q.push_back(16'hFF38);
      pulse_start();
      wait_quiet(400);
      check("neg_temp", temp_data, 16'hFFE7);
      check("neg_count", sample_count, 16'd2);

      // Hysteresis
      alarm_hi = 16'h0190; alarm_lo = 16'h0140;
      dir_q.push_back(16'h1900);
      pulse_start();
      wait_quiet(400);
      check("hyst_set", 16'(alarm), 16'd1);
      dir_q.push_back(16'h0B40);
      pulse_start();
      wait_quiet(400);
      check("hyst_temp_mid", temp_data, 16'h0168);
      check("hyst_hold", 16'(alarm), 16'd1);
      dir_q.push_back(16'h0800);
      pulse_start();
      wait_quiet(400);
      check("hyst_clear", 16'(alarm), 16'd0);

      // Two extra requests during one frame: one pends, one is dropped
      vcount = 0;
      for (int i = 0; i < 400; i++) begin
         start_once = (i == 0 || i == 20 || i == 40);
         @(negedge tb_ACLK);
         if (temp_valid) vcount++;
      end
      start_once = 1'b0;
      check("pending_frames", 16'(vcount), 16'd2);
      check("pending_idle", 16'(busy), 16'd0);
      check("pending_count", sample_count, model_cnt);

      // Periodic with overlap: back-to-back frames, 1-cycle IDLE gap
      enable = 1'b1;
      vcount = 0;
      gap = 0;
      busy_seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         start_once = (i == 350);
         @(negedge tb_ACLK);
         if (temp_valid) vcount++;
         if (busy) begin
            if (busy_seen && gap != 0) check("idle_gap", 16'(gap), 16'd1);
            busy_seen = 1'b1;
            gap = 0;
         end else if (busy_seen) begin
            gap++;
         end
      end
      start_once = 1'b0;
      enable = 1'b0;
      check("periodic_frames", 16'(vcount), 16'd6);
      wait_quiet(1000);
      check("periodic_drain", 16'(exp_temp_q.size()), 16'd0);
      check("periodic_count", sample_count, model_cnt);

      // Reset during SHIFT bit 7
      pulse_start();
      n = 1;
      while (n < 72) begin
         @(negedge tb_ACLK);
         n++;
      end
      ARESET = 1'b1;
      flush_model();
      @(negedge tb_ACLK);
      check("midrst_cs_n", 16'(sensor_cs_n), 16'd1);
      check("midrst_sclk", 16'(sensor_sclk), 16'd0);
      check("midrst_busy", 16'(busy), 16'd0);
      check("midrst_valid", 16'(temp_valid), 16'd0);
      check("midrst_count", sample_count, 16'd0);
      @(negedge tb_ACLK);
      ARESET = 1'b0;
      @(negedge tb_ACLK);
      pulse_start();
      wait_quiet(400);
      check("post_rst_count", sample_count, 16'd1);
      check("final_drain", 16'(exp_temp_q.size()), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
